// File: rtl/if_stage.sv
// Instruction fetch stage: issues sequential fetches, buffers returned words in a
// 2-entry skid FIFO, and handles aligned redirects and misaligned-target faults.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_fault
);

  typedef enum logic [1:0] {RUN = 2'd0, FAULT = 2'd1, HALT = 2'd2} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } entry_t;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [31:0]       inflight_pc_q, inflight_pc_d;
  logic [31:0]       fault_pc_q, fault_pc_d;
  logic [1:0]        count_q, count_d;
  entry_t [1:0]      fifo_q, fifo_d;

  logic              redir_ok, redir_bad;
  logic              pop, push, fault_push, wr, wr_idx, issue;
  logic [2:0]        occ_after_pop;

  always_comb begin
    redir_ok   = redirect_valid & (redirect_pc[1:0] == 2'b00);
    redir_bad  = redirect_valid & (redirect_pc[1:0] != 2'b00);
    out_valid  = rst_n & (count_q != 2'd0) & ~redirect_valid;
    pop        = out_valid & out_ready;
    push       = inflight_q & ~redirect_valid;
    fault_push = (state_q == FAULT) & ~redirect_valid;
    wr         = push | fault_push;
    wr_idx     = (count_q - {1'b0, pop}) != 2'd0;
    // Only issue when the returning word is guaranteed a free FIFO slot.
    occ_after_pop = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue      = (state_q == RUN) & ~redirect_valid & (occ_after_pop <= 3'd1);

    imem_en    = rst_n & (redir_ok | issue);
    imem_addr  = redir_ok ? redirect_pc : pc_q;

    out_pc     = out_valid ? fifo_q[0].pc    : 32'd0;
    out_instr  = out_valid ? fifo_q[0].instr : NOP_WORD;
    out_fault  = out_valid ? fifo_q[0].fault : 1'b0;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    fault_pc_d    = fault_pc_q;
    fifo_d        = fifo_q;
    count_d       = count_q;
    if (redir_ok) begin
      count_d       = 2'd0;
      inflight_d    = 1'b1;
      inflight_pc_d = redirect_pc;
      pc_d          = redirect_pc + 32'd4;
      state_d       = RUN;
    end else if (redir_bad) begin
      count_d    = 2'd0;
      fault_pc_d = redirect_pc;
      state_d    = FAULT;
    end else begin
      if (pop) fifo_d[0] = fifo_q[1];
      if (push)
        fifo_d[wr_idx] = '{pc: inflight_pc_q, instr: imem_rdata, fault: 1'b0};
      else if (fault_push)
        fifo_d[wr_idx] = '{pc: fault_pc_q, instr: NOP_WORD, fault: 1'b1};
      count_d = count_q + {1'b0, wr} - {1'b0, pop};
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd4;
      end
      if (state_q == FAULT) state_d = HALT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      fault_pc_q    <= 32'd0;
      count_q       <= 2'd0;
      fifo_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      fault_pc_q    <= fault_pc_d;
      count_q       <= count_d;
      fifo_q        <= fifo_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: stream, backpressure, redirects, misaligned fault,
// PC wrap (second instance) and mid-run reset.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_en, w_imem_en;
  logic [31:0] imem_addr, w_imem_addr;
  logic [31:0] imem_rdata, w_imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid, w_out_valid;
  logic        out_ready;
  logic [31:0] out_pc, w_out_pc;
  logic [31:0] out_instr, w_out_instr;
  logic        out_fault, w_out_fault;
  logic        w_redirect_valid, w_out_ready;
  logic [31:0] w_redirect_pc;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_stage u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .out_fault(out_fault)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_en(w_imem_en), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_pc(w_out_pc), .out_instr(w_out_instr), .out_fault(w_out_fault)
  );

  // Memory word = tag | word index, so every address returns a distinct word.
  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'hC000_0000 | {2'b00, a[31:2]};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    imem_rdata   = 32'd0;
    w_imem_rdata = 32'd0;
  end

  always @(posedge clk) begin
    if (imem_en)   imem_rdata   <= memw(imem_addr);
    if (w_imem_en) w_imem_rdata <= memw(w_imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".pc"},    out_pc,             pc);
    chk({tag, ".instr"}, out_instr,          memw(pc));
    chk({tag, ".fault"}, {31'd0, out_fault}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
    w_out_ready = 1'b1; w_redirect_valid = 1'b0; w_redirect_pc = 32'd0;

    nxt(); nxt(); #2;
    chk("rst.en",    {31'd0, imem_en},   32'd0);
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.pc",    out_pc,             32'd0);
    chk("rst.instr", out_instr,          NOP);
    chk("rst.fault", {31'd0, out_fault}, 32'd0);

    // Stream: one fetch per cycle, entries two cycles behind the issue.
    nxt(); rst_n = 1'b1; #2;
    for (int k = 0; k < 6; k++) begin
      if (k != 0) begin nxt(); #2; end
      chk("str.en",   {31'd0, imem_en}, 32'd1);
      chk("str.addr", imem_addr,        32'(4 * k));
      if (k < 2) chk("str.novalid", {31'd0, out_valid}, 32'd0);
      else       chk_out("str", 32'(4 * (k - 2)));
      if (k == 0) chk("wrap.a0", w_imem_addr, 32'hFFFF_FFFC);
      if (k == 1) chk("wrap.a1", w_imem_addr, 32'h0000_0000);
      if (k == 2) chk("wrap.p0", w_out_pc,    32'hFFFF_FFFC);
      if (k == 3) chk("wrap.p1", w_out_pc,    32'h0000_0000);
    end

    // Backpressure: head held, FIFO fills, fetch stalls.
    nxt(); out_ready = 1'b0; #2;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) begin nxt(); #2; end
      chk_out("bp.hold", 32'd16);
      chk("bp.en", {31'd0, imem_en}, 32'd0);
    end
    nxt(); out_ready = 1'b1; #2;
    chk("bp.resume", imem_addr, 32'd24);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin nxt(); #2; end
      chk_out("bp.drain", 32'(16 + 4 * k));
    end

    // Aligned redirect with an occupied FIFO and a fetch in flight.
    nxt(); redirect_valid = 1'b1; redirect_pc = 32'h100; #2;
    chk("rd.valid", {31'd0, out_valid}, 32'd0);
    chk("rd.en",    {31'd0, imem_en},   32'd1);
    chk("rd.addr",  imem_addr,          32'h100);
    nxt(); redirect_valid = 1'b0; #2;
    chk("rd.stale", {31'd0, out_valid}, 32'd0);
    chk("rd.addr2", imem_addr,          32'h104);
    for (int k = 0; k < 3; k++) begin
      nxt(); #2;
      chk_out("rd.seq", 32'(32'h100 + 4 * k));
    end

    // Misaligned redirect: single fault entry, then idle.
    nxt(); redirect_valid = 1'b1; redirect_pc = 32'h102; #2;
    chk("mis.valid0", {31'd0, out_valid}, 32'd0);
    chk("mis.en0",    {31'd0, imem_en},   32'd0);
    nxt(); redirect_valid = 1'b0; #2;
    chk("mis.valid1", {31'd0, out_valid}, 32'd0);
    chk("mis.en1",    {31'd0, imem_en},   32'd0);
    nxt(); #2;
    chk("mis.valid", {31'd0, out_valid}, 32'd1);
    chk("mis.pc",    out_pc,             32'h102);
    chk("mis.instr", out_instr,          NOP);
    chk("mis.fault", {31'd0, out_fault}, 32'd1);
    chk("mis.en2",   {31'd0, imem_en},   32'd0);
    for (int k = 0; k < 3; k++) begin
      nxt(); #2;
      chk("halt.valid", {31'd0, out_valid}, 32'd0);
      chk("halt.en",    {31'd0, imem_en},   32'd0);
      chk("halt.instr", out_instr,          NOP);
    end
    nxt(); redirect_valid = 1'b1; redirect_pc = 32'h200; #2;
    chk("res.en",   {31'd0, imem_en}, 32'd1);
    chk("res.addr", imem_addr,        32'h200);
    nxt(); redirect_valid = 1'b0; #2;
    chk("res.addr2", imem_addr, 32'h204);

    // Fill the FIFO, then reset mid-run (with a redirect that must be ignored).
    nxt(); out_ready = 1'b0; #2;
    chk_out("res.first", 32'h200);
    nxt(); #2;
    chk_out("mr.full", 32'h200);
    chk("mr.en", {31'd0, imem_en}, 32'd0);
    nxt(); rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300; #2;
    chk("mr.valid", {31'd0, out_valid}, 32'd0);
    chk("mr.en0",   {31'd0, imem_en},   32'd0);
    nxt(); rst_n = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1; #2;
    chk("mr.valid1", {31'd0, out_valid}, 32'd0);
    chk("mr.addr",   imem_addr,          32'd0);
    chk("mr.en1",    {31'd0, imem_en},   32'd1);
    chk("mr.pc",     out_pc,             32'd0);
    chk("mr.instr",  out_instr,          NOP);
    nxt(); #2;
    chk("mr.addr2", imem_addr, 32'd4);
    nxt(); #2;
    chk_out("mr.out", 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
